// File: rtl/tinyalu_pkg.sv
// Shared types and widths for the TinyALU requester slice.
package tinyalu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  // Opcodes this requester forwards to the ALU; everything else is answered locally.
  function automatic logic is_alu_op(input logic [2:0] code);
    return (code == ADD_OP) || (code == AND_OP) || (code == XOR_OP);
  endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Counts cycles start has been held; flags when the count reaches TIMEOUT_CYCLES.
module alu_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Clear loads 1: the cycle in which start rises is already the first held cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= CNT_W'(1);
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    expired = (count == CNT_W'(TIMEOUT_CYCLES));
  end

endmodule

// File: rtl/alu_requester.sv
// Initiator for the TinyALU start/done handshake with valid/ready command and response ports.
module alu_requester
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        op,
  output logic              start,
  input  logic              done_aax,
  input  logic [RES_W-1:0]  result_aax,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_nxt, b_nxt;
  logic [2:0]        op_nxt;
  logic              start_nxt;
  logic              cmd_ready_nxt;
  logic              rsp_valid_nxt;
  logic [RES_W-1:0]  rsp_result_nxt;
  logic              rsp_err_nxt;
  logic              timer_clear;
  logic              timer_expired;

  alu_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (state == ST_ISSUE),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      A          <= '0;
      B          <= '0;
      op         <= '0;
      start      <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      A          <= a_nxt;
      B          <= b_nxt;
      op         <= op_nxt;
      start      <= start_nxt;
      cmd_ready  <= cmd_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_err    <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    a_nxt          = A;
    b_nxt          = B;
    op_nxt         = op;
    start_nxt      = start;
    rsp_result_nxt = rsp_result;
    rsp_err_nxt    = rsp_err;
    timer_clear    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (is_alu_op(cmd_op)) begin
            a_nxt       = cmd_a;
            b_nxt       = cmd_b;
            op_nxt      = cmd_op;
            start_nxt   = 1'b1;
            timer_clear = 1'b1;
            state_nxt   = ST_ISSUE;
          end else begin
            rsp_result_nxt = '0;
            rsp_err_nxt    = (cmd_op != NO_OP);
            state_nxt      = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        // done_aax is checked first so a completion in the timeout cycle still succeeds.
        if (done_aax) begin
          rsp_result_nxt = result_aax;
          rsp_err_nxt    = 1'b0;
          start_nxt      = 1'b0;
          state_nxt      = ST_RESP;
        end else if (timer_expired) begin
          rsp_result_nxt = '0;
          rsp_err_nxt    = 1'b1;
          start_nxt      = 1'b0;
          state_nxt      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        start_nxt = 1'b0;
      end
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    rsp_valid_nxt = (state_nxt == ST_RESP);
  end

endmodule

// File: tb/tb_alu_requester.sv
// Randomized self-checking bench for alu_requester against a transaction-level reference model.
module tb_alu_requester;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done_aax = 1'b0;
  logic [15:0] result_aax = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic        rsp_err;

  logic        alu_en = 1'b1;
  logic        rand_rdy = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  alu_requester #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .A         (A),
    .B         (B),
    .op        (op),
    .start     (start),
    .done_aax  (done_aax),
    .result_aax(result_aax),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-cycle ALU stand-in: answers one cycle after sampling start, operating on the DUT's A/B/op.
  always @(posedge clk) begin
    done_aax <= alu_en && start;
    case (op)
      3'b001:  result_aax <= 16'(A) + 16'(B);
      3'b010:  result_aax <= {8'h00, A & B};
      3'b011:  result_aax <= {8'h00, A ^ B};
      default: result_aax <= 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          starts;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_cyc = 0;
  int   start_cnt = 0;
  bit   have_first = 0;

  function automatic exp_t predict(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                   input logic en);
    exp_t e;
    e.a = a; e.b = b; e.opc = o;
    e.res = 16'h0; e.err = 1'b0; e.lat = 0; e.starts = 0;
    if (o == 3'b000) begin
      // answered locally, no ALU traffic
    end else if (o >= 3'b100) begin
      e.err = 1'b1;
    end else if (!en) begin
      e.err = 1'b1; e.lat = TMO; e.starts = TMO;
    end else begin
      e.lat = 2; e.starts = 2;
      if (o == 3'b001) e.res = 16'(a) + 16'(b);
      else if (o == 3'b010) e.res = 16'(a & b);
      else e.res = 16'(a ^ b);
    end
    return e;
  endfunction

  // Monitor samples on the falling edge, between DUT updates.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      have_first = 0;
      start_cnt  = 0;
    end else begin
      cyc++;
      if (start) begin
        start_cnt++;
        if (exp_q.size() > 0) begin
          check("issue_A", A, exp_q[0].a);
          check("issue_B", B, exp_q[0].b);
          check("issue_op", op, exp_q[0].opc);
        end
      end
      if (rsp_valid) begin
        if (!have_first) begin
          have_first = 1;
          first_cyc  = cyc;
        end
        check("rsp_cmd_ready_low", cmd_ready, 0);
        check("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() > 0) begin
          check("rsp_result", rsp_result, exp_q[0].res);
          check("rsp_err", rsp_err, exp_q[0].err);
          if (rsp_ready) begin
            check("rsp_latency", first_cyc - acc_cyc - 1, exp_q[0].lat);
            check("start_cycles", start_cnt, exp_q[0].starts);
            void'(exp_q.pop_front());
          end
        end
        if (rsp_ready) have_first = 0;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(predict(cmd_op, cmd_a, cmd_b, alu_en));
        acc_cyc   = cyc;
        start_cnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned n = 0;
    logic        rdy = 1'b0;
    cmd_valid = 1'b1; cmd_op = o; cmd_a = a; cmd_b = b;
    while (!rdy && n < 200) begin
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("accept_bound", rdy, 1);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_bound", n < 200, 1);
  endtask

  task automatic idle_cycles(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_start", start, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_ABop", {A, B, 5'(op)}, 0);
    idle_cycles(2);
    check("rst_hold_cmd_ready", cmd_ready, 0);
    reset_n = 1'b1;
    idle_cycles(1);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // add with carry into bit 8
    send(3'b001, 8'hFF, 8'h01);
    wait_drain();

    // back-to-back xor / and with trailing done arriving after each capture
    send(3'b011, 8'hA5, 8'h0F);
    send(3'b010, 8'hA5, 8'h0F);
    wait_drain();
    idle_cycles(3);
    check("no_extra_rsp", rsp_valid, 0);

    // locally answered opcodes
    send(3'b000, 8'h12, 8'h34);
    send(3'b101, 8'h56, 8'h78);
    wait_drain();

    // back-pressure with a competing command held on the port
    rsp_ready = 1'b0;
    send(3'b001, 8'h10, 8'h20);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h3C; cmd_b = 8'hFF;
    idle_cycles(3);
    for (int unsigned i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, 16'h0030);
      check("stall_cmd_ready", cmd_ready, 0);
      idle_cycles(1);
    end
    rsp_ready = 1'b1;
    send(3'b011, 8'h3C, 8'hFF);
    wait_drain();

    // ALU never answers
    alu_en = 1'b0;
    send(3'b010, 8'hF0, 8'h3C);
    wait_drain();

    // reset while start is high aborts without a response
    send(3'b001, 8'h01, 8'h02);
    idle_cycles(3);
    check("pre_abort_start", start, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_start", start, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    idle_cycles(2);
    reset_n = 1'b1;
    alu_en  = 1'b1;
    idle_cycles(1);
    send(3'b001, 8'h7F, 8'h81);
    wait_drain();

    // randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int unsigned i = 0; i < 60; i++) begin
      wait_drain();
      alu_en = ($urandom_range(0, 7) != 0);
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    wait_drain();
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    idle_cycles(4);
    check("final_idle_rsp_valid", rsp_valid, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
